// File: rtl/dpram_pkg.sv
// Shared constants and state encoding for the byte-enable dual-port RAM.
// Latency 1+OUT_REG cycles per read; no backpressure, every accepted request completes.
package dpram_pkg;

   localparam int RD_FIRST = 0;
   localparam int WR_FIRST = 1;

   typedef enum logic {
      ST_CLEAR,
      ST_READY
   } state_t;

endpackage

// File: rtl/dpram_rd_pipe.sv
// Per-port read return path: write-first lane merge, optional output stage, dvld pulse.
// Latency 1+OUT_REG cycles after accept; no backpressure, dout holds between completions.
module dpram_rd_pipe
   import dpram_pkg::*;
#(
   parameter int NB      = 4,
   parameter int RD_MODE = RD_FIRST,
   parameter int OUT_REG = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req,
   input  logic [8*NB-1:0] mem_dat,
   input  logic [8*NB-1:0] din,
   input  logic [NB-1:0]   we,
   output logic [8*NB-1:0] dout,
   output logic            dvld
);

   localparam int DW = 8 * NB;

   logic [DW-1:0] merged;
   logic [DW-1:0] s1_dat_d, s1_dat_q;
   logic          s1_vld_d, s1_vld_q;

   // mem_dat is the pre-write word, so the other port's lanes are always read-first.
   always_comb begin
      merged = mem_dat;
      for (int i = 0; i < NB; i++) begin
         if (RD_MODE == WR_FIRST && we[i]) begin
            merged[8*i +: 8] = din[8*i +: 8];
         end
      end
      s1_dat_d = req ? merged : s1_dat_q;
      s1_vld_d = req;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_dat_q <= '0;
         s1_vld_q <= 1'b0;
      end else begin
         s1_dat_q <= s1_dat_d;
         s1_vld_q <= s1_vld_d;
      end
   end

   generate
      if (OUT_REG != 0) begin : g_out_reg
         logic [DW-1:0] s2_dat_d, s2_dat_q;
         logic          s2_vld_d, s2_vld_q;

         always_comb begin
            s2_dat_d = s1_vld_q ? s1_dat_q : s2_dat_q;
            s2_vld_d = s1_vld_q;
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               s2_dat_q <= '0;
               s2_vld_q <= 1'b0;
            end else begin
               s2_dat_q <= s2_dat_d;
               s2_vld_q <= s2_vld_d;
            end
         end

         assign dout = s2_dat_q;
         assign dvld = s2_vld_q;
      end else begin : g_no_out_reg
         assign dout = s1_dat_q;
         assign dvld = s1_vld_q;
      end
   endgenerate

endmodule

// File: rtl/dpram_be_pipe.sv
// True dual-port byte-enable RAM with post-reset clear engine and same-address collision flag.
// Read latency 1+OUT_REG; no stalls once ready, requests during clear are dropped.
module dpram_be_pipe
   import dpram_pkg::*;
#(
   parameter int AW       = 8,
   parameter int NB       = 4,
   parameter int RD_MODE  = RD_FIRST,
   parameter int OUT_REG  = 0,
   parameter int INIT_CLR = 1
) (
   input  logic            clk,
   input  logic            rst,
   output logic            init_busy,
   input  logic            en_a,
   input  logic [AW-1:0]   addr_a,
   input  logic [8*NB-1:0] din_a,
   input  logic [NB-1:0]   we_a,
   output logic [8*NB-1:0] dout_a,
   output logic            dvld_a,
   input  logic            en_b,
   input  logic [AW-1:0]   addr_b,
   input  logic [8*NB-1:0] din_b,
   input  logic [NB-1:0]   we_b,
   output logic [8*NB-1:0] dout_b,
   output logic            dvld_b,
   output logic            col_err
);

   localparam int DW    = 8 * NB;
   localparam int DEPTH = 2 ** AW;

   logic [DW-1:0] mem_q [DEPTH];

   state_t        state_d, state_q;
   logic [AW-1:0] clr_addr_d, clr_addr_q;
   logic          init_busy_d, init_busy_q;
   logic          col_err_d, col_err_q;
   logic          req_a, req_b;
   logic [DW-1:0] rd_a, rd_b;

   assign req_a = en_a & ~init_busy_q & ~rst;
   assign req_b = en_b & ~init_busy_q & ~rst;
   assign rd_a  = mem_q[addr_a];
   assign rd_b  = mem_q[addr_b];

   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      if (state_q == ST_CLEAR) begin
         clr_addr_d = clr_addr_q + AW'(1);
         if (clr_addr_q == '1) begin
            state_d = ST_READY;
         end
      end
      init_busy_d = (state_d == ST_CLEAR);
      col_err_d   = req_a & req_b & (addr_a == addr_b) & ((|we_a) | (|we_b));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= (INIT_CLR != 0) ? ST_CLEAR : ST_READY;
         clr_addr_q  <= '0;
         init_busy_q <= (INIT_CLR != 0);
         col_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         clr_addr_q  <= clr_addr_d;
         init_busy_q <= init_busy_d;
         col_err_q   <= col_err_d;
      end
   end

   // Port A's lane write is issued last so it wins on a same-address, same-lane clash.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state_q == ST_CLEAR) begin
            mem_q[clr_addr_q] <= '0;
         end else begin
            for (int i = 0; i < NB; i++) begin
               if (req_b && we_b[i]) begin
                  mem_q[addr_b][8*i +: 8] <= din_b[8*i +: 8];
               end
               if (req_a && we_a[i]) begin
                  mem_q[addr_a][8*i +: 8] <= din_a[8*i +: 8];
               end
            end
         end
      end
   end

   dpram_rd_pipe #(.NB(NB), .RD_MODE(RD_MODE), .OUT_REG(OUT_REG)) u_rd_a (
      .clk     (clk),
      .rst     (rst),
      .req     (req_a),
      .mem_dat (rd_a),
      .din     (din_a),
      .we      (we_a),
      .dout    (dout_a),
      .dvld    (dvld_a)
   );

   dpram_rd_pipe #(.NB(NB), .RD_MODE(RD_MODE), .OUT_REG(OUT_REG)) u_rd_b (
      .clk     (clk),
      .rst     (rst),
      .req     (req_b),
      .mem_dat (rd_b),
      .din     (din_b),
      .we      (we_b),
      .dout    (dout_b),
      .dvld    (dvld_b)
   );

   assign init_busy = init_busy_q;
   assign col_err   = col_err_q;

endmodule

// File: tb/tb_dpram_be_pipe.sv
// Two DUT configurations (read-first/no out reg, write-first/out reg) driven in lockstep
// and compared every cycle against a word-array reference model.
module tb_dpram_be_pipe;

   localparam int AW    = 4;
   localparam int NB    = 4;
   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en_a = 1'b0, en_b = 1'b0;
   logic [3:0]  addr_a = '0, addr_b = '0;
   logic [31:0] din_a = '0, din_b = '0;
   logic [3:0]  we_a = '0, we_b = '0;

   logic        busy0, dvld0_a, dvld0_b, col0;
   logic [31:0] dout0_a, dout0_b;
   logic        busy1, dvld1_a, dvld1_b, col1;
   logic [31:0] dout1_a, dout1_b;

   always #5 clk = ~clk;

   dpram_be_pipe #(.AW(AW), .NB(NB), .RD_MODE(0), .OUT_REG(0), .INIT_CLR(1)) u_dut0 (
      .clk(clk), .rst(rst), .init_busy(busy0),
      .en_a(en_a), .addr_a(addr_a), .din_a(din_a), .we_a(we_a), .dout_a(dout0_a), .dvld_a(dvld0_a),
      .en_b(en_b), .addr_b(addr_b), .din_b(din_b), .we_b(we_b), .dout_b(dout0_b), .dvld_b(dvld0_b),
      .col_err(col0)
   );

   dpram_be_pipe #(.AW(AW), .NB(NB), .RD_MODE(1), .OUT_REG(1), .INIT_CLR(1)) u_dut1 (
      .clk(clk), .rst(rst), .init_busy(busy1),
      .en_a(en_a), .addr_a(addr_a), .din_a(din_a), .we_a(we_a), .dout_a(dout1_a), .dvld_a(dvld1_a),
      .en_b(en_b), .addr_b(addr_b), .din_b(din_b), .we_b(we_b), .dout_b(dout1_b), .dvld_b(dvld1_b),
      .col_err(col1)
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference model state: memory contents, clear countdown, expected outputs.
   logic [31:0] mdl_mem [DEPTH];
   int          busy_left = 0;
   logic        x0_vld_a = 0, x0_vld_b = 0, x1_vld_a = 0, x1_vld_b = 0, x_col = 0;
   logic [31:0] x0_dat_a = 0, x0_dat_b = 0, x1_dat_a = 0, x1_dat_b = 0;
   logic        p_vld_a = 0, p_vld_b = 0;
   logic [31:0] p_dat_a = 0, p_dat_b = 0;

   function automatic logic [31:0] merge_lanes(input logic [31:0] old, input logic [31:0] din,
                                               input logic [3:0] we);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++) if (we[i]) r[8*i +: 8] = din[8*i +: 8];
      return r;
   endfunction

   task automatic model_edge();
      logic        acc_a, acc_b;
      logic [31:0] old_a, old_b;
      if (rst) begin
         busy_left = DEPTH;
         for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;
         {x0_vld_a, x0_vld_b, x1_vld_a, x1_vld_b, x_col, p_vld_a, p_vld_b} = '0;
         {x0_dat_a, x0_dat_b, x1_dat_a, x1_dat_b} = '0;
      end else begin
         acc_a = en_a && (busy_left == 0);
         acc_b = en_b && (busy_left == 0);
         if (busy_left > 0) busy_left--;
         old_a = mdl_mem[addr_a];
         old_b = mdl_mem[addr_b];
         x_col = acc_a && acc_b && (addr_a == addr_b) && (we_a != 0 || we_b != 0);
         // Read-first config sees the old word one cycle later.
         x0_vld_a = acc_a;
         x0_vld_b = acc_b;
         if (acc_a) x0_dat_a = old_a;
         if (acc_b) x0_dat_b = old_b;
         // Write-first config sees its own merged word two cycles later.
         x1_vld_a = p_vld_a;
         x1_vld_b = p_vld_b;
         if (p_vld_a) x1_dat_a = p_dat_a;
         if (p_vld_b) x1_dat_b = p_dat_b;
         p_vld_a = acc_a;
         p_vld_b = acc_b;
         if (acc_a) p_dat_a = merge_lanes(old_a, din_a, we_a);
         if (acc_b) p_dat_b = merge_lanes(old_b, din_b, we_b);
         if (acc_b) mdl_mem[addr_b] = merge_lanes(mdl_mem[addr_b], din_b, we_b);
         if (acc_a) mdl_mem[addr_a] = merge_lanes(mdl_mem[addr_a], din_a, we_a);
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_all();
      logic xb;
      xb = (busy_left > 0);
      chk("busy0",   32'(busy0),   32'(xb));
      chk("busy1",   32'(busy1),   32'(xb));
      chk("col0",    32'(col0),    32'(x_col));
      chk("col1",    32'(col1),    32'(x_col));
      chk("dvld0_a", 32'(dvld0_a), 32'(x0_vld_a));
      chk("dvld0_b", 32'(dvld0_b), 32'(x0_vld_b));
      chk("dvld1_a", 32'(dvld1_a), 32'(x1_vld_a));
      chk("dvld1_b", 32'(dvld1_b), 32'(x1_vld_b));
      chk("dout0_a", dout0_a, x0_dat_a);
      chk("dout0_b", dout0_b, x0_dat_b);
      chk("dout1_a", dout1_a, x1_dat_a);
      chk("dout1_b", dout1_b, x1_dat_b);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
   endtask

   task automatic drive(input logic ea, input logic [3:0] aa, input logic [31:0] da, input logic [3:0] wa,
                        input logic eb, input logic [3:0] ab, input logic [31:0] db, input logic [3:0] wb);
      en_a = ea; addr_a = aa; din_a = da; we_a = wa;
      en_b = eb; addr_b = ab; din_b = db; we_b = wb;
   endtask

   task automatic idle(input int n);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      logic [3:0] ra, rb;
      // Reset and clear; requests during clear must be dropped.
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         drive(1, 4'(i), 32'hDEAD0000 | 32'(i), 4'hF, 1, 4'(i), 0, 0);
         step();
      end
      idle(1);
      for (int i = 0; i < DEPTH; i++) begin
         drive(1, 4'(i), 0, 0, 1, 4'(DEPTH - 1 - i), 0, 0);
         step();
      end
      idle(2);

      // Fill with data, then reset at clr_addr=7 and check the clear restarts in full.
      for (int i = 0; i < DEPTH; i++) begin
         drive(1, 4'(i), $urandom | 32'h1, 4'hF, 0, 0, 0, 0);
         step();
      end
      idle(1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      idle(7);
      rst = 1'b1;
      step();
      rst = 1'b0;
      idle(DEPTH + 1);
      for (int i = 0; i < DEPTH; i++) begin
         drive(1, 4'(i), 0, 0, 1, 4'(i), 0, 0);
         step();
      end
      idle(2);

      // Byte lanes.
      drive(1, 3, 32'h11223344, 4'hF, 0, 0, 0, 0); step();
      drive(1, 3, 32'hAABBCCDD, 4'b0101, 0, 0, 0, 0); step();
      drive(1, 3, 0, 0, 0, 0, 0, 0); step();
      chk("t2_vld0", 32'(dvld0_a), 32'h1);
      chk("t2_rd0", dout0_a, 32'h11BB33DD);
      idle(1);
      chk("t2_vld1", 32'(dvld1_a), 32'h1);
      chk("t2_rd1", dout1_a, 32'h11BB33DD);
      idle(1);

      // Same-port read-during-write on a zeroed word.
      drive(1, 5, 32'hFFFFFFFF, 4'hF, 0, 0, 0, 0); step();
      idle(2);
      chk("t3_rf", dout0_a, 32'h00000000);
      chk("t3_wf", dout1_a, 32'hFFFFFFFF);

      // Cross-port collision with partially overlapping lanes.
      drive(1, 9, 32'hAAAAAAAA, 4'b0011, 1, 9, 32'hBBBBBBBB, 4'b0110); step();
      chk("t4_col", 32'(col0), 32'h1);
      drive(1, 9, 0, 0, 1, 9, 0, 0); step();
      chk("t4_nocol", 32'(col0), 32'h0);
      chk("t4_rd0", dout0_a, 32'h00BBAAAA);
      idle(2);
      chk("t4_rd1a", dout1_a, 32'h00BBAAAA);
      chk("t4_rd1b", dout1_b, 32'h00BBAAAA);

      // Random back-to-back traffic on both ports.
      for (int i = 0; i < 64; i++) begin
         ra = 4'($urandom_range(0, 15));
         rb = ($urandom_range(0, 3) == 0) ? ra : 4'($urandom_range(0, 15));
         drive($urandom_range(0, 9) != 0, ra, $urandom,
               ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15)),
               $urandom_range(0, 9) != 0, rb, $urandom,
               ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15)));
         step();
      end
      idle(3);
      for (int i = 0; i < DEPTH; i++) begin
         drive(1, 4'(i), 0, 0, 1, 4'(i), 0, 0);
         step();
      end
      idle(3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
